cpld_uart_responder: RTL and testbench
======================================

Name: cpld_uart_responder

Overview:
Device-side model and FPGA replacement for the CPLD serial controller that the CPU's memory unit drives through uart_rdn/uart_wrn and base_ram_data[7:0]. It responds to read and write strobes on the shared 8-bit data lane. It reports uart_dataready, uart_tbre and uart_tsre, and converts bytes to and from 8N1 serial on txd/rxd. It is used in simulation opposite the CPU-side bus master, and as a synthesizable bridge when the CPLD path is bypassed.

Parameters:
BAUD_DIV, 96, clk cycles per serial bit (11.0592 MHz / 115200); legal range 4..65535.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
uart_rdn  in  1  read strobe, active low, synchronous to clk
uart_wrn  in  1  write strobe, active low, synchronous to clk
data_i  in  8  bus byte from the master (base_ram_data[7:0])
data_o  out  8  bus byte to the master
data_oe  out  1  1 = responder drives data_o onto the shared lane
uart_dataready  out  1  RX holding register holds an unread byte
uart_tbre  out  1  TX holding register empty
uart_tsre  out  1  TX shift register empty (line idle)
overrun  out  1  sticky: a received byte overwrote an unread byte
txd  out  1  serial out, idle high
rxd  in  1  serial in, asynchronous

Behaviour:
- Reset values (async assert, sync release): data_o=0, data_oe=0, uart_dataready=0, uart_tbre=1, uart_tsre=1, overrun=0, txd=1, RX and TX FSMs in IDLE.
- Strobe edges: uart_rdn and uart_wrn are registered once (prev value, reset 1). A release is a clock edge where the strobe is 1 and its prev value is 0.
- Read: data_oe = ~uart_rdn (combinational). data_o = rx_hold, registered. On rdn release, uart_dataready<=0 and overrun<=0.
- Write: on wrn release, tx_hold<=data_i and uart_tbre<=0. A write release while uart_tbre=0 is ignored; tx_hold is unchanged.
- Both releases on the same edge: both are processed independently.
- TX FSM, states IDLE/START/DATA/STOP:
  - In IDLE with uart_tbre=0: on the next edge load the shifter from tx_hold, set uart_tbre<=1, uart_tsre<=0, txd<=0, enter START.
  - Each bit lasts BAUD_DIV cycles. START sends 0. DATA sends bits 0..7, LSB first. STOP sends 1.
  - At the end of STOP: if uart_tbre=0, go straight to the next START with no idle gap. Otherwise go to IDLE and set uart_tsre<=1.
  - Frame length is exactly 10*BAUD_DIV cycles.
- RX path: rxd passes through a 2-flop synchronizer (reset 1).
- RX FSM, states IDLE/START/DATA/STOP:
  - IDLE: a synchronized 1->0 transition enters START.
  - START: wait BAUD_DIV/2 cycles (integer floor). If the line is still 0, enter DATA; otherwise it was a glitch, return to IDLE.
  - DATA: sample every BAUD_DIV cycles; 8 samples, LSB first.
  - STOP: sample after a further BAUD_DIV cycles. If the stop bit is 1: rx_hold<=byte, uart_dataready<=1 on the next edge, and overrun<=1 if uart_dataready was already 1. If the stop bit is 0 (framing error): discard the byte and leave all flags unchanged. Either way return to IDLE, which requires the line to return to 1 before a new start is accepted.
- Byte completion on the same edge as an rdn release: the new byte wins. uart_dataready stays 1 and overrun is not set.
- Counters: bit-period counter is 16 bits, reloads at BAUD_DIV-1 and counts down to 0. Bit index is 3 bits. No wrap beyond 8 data bits.
- Reset asserted mid-frame: txd returns to 1 immediately and the partial RX byte is lost.

Test Plan:
- Reset (BAUD_DIV=16): assert rst=0 mid-frame -> txd=1, uart_tbre=1, uart_tsre=1, uart_dataready=0, data_oe=0, all immediately.
- Write 0xA5 (wrn low 2 cycles, then released at edge E) -> tbre=0 after E; tbre=1 and tsre=0 after E+1; txd = 0,1,0,1,0,0,1,0,1,1 with each bit 16 cycles; tsre=1 after edge E+1+160.
- Back-to-back: write 0x55, then write 0x0F as soon as tbre=1 -> two frames with no idle gap between stop and start; a third write while tbre=0 is ignored.
- RX 0x3C at BAUD_DIV=16 -> dataready=1 about 152 cycles after the start edge; rdn low gives data_oe=1, data_o=0x3C; rdn release gives dataready=0.
- Overrun: receive 0x11, then 0x22 without reading -> data_o=0x22, overrun=1; after a read, overrun=0.
- Framing error (stop bit 0) and a 3-cycle start glitch -> no dataready and rx_hold unchanged in both cases.

Source files
------------

// File: rtl/cpld_uart_responder.sv
// -----------------------------------------------------------------------------
// cpld_uart_responder
// Device-side stand-in for the CPLD serial controller behind the CPU memory
// unit. Answers uart_rdn/uart_wrn strobes on the shared 8-bit data lane,
// reports holding/shift register status, and converts bytes to and from
// 8N1 serial.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   uart_rdn       read strobe, active low, clk-synchronous
//   uart_wrn       write strobe, active low, clk-synchronous
//   data_i[7:0]    byte written by the bus master
//   data_o[7:0]    RX holding register, registered
//   data_oe        drive enable for data_o (follows ~uart_rdn directly)
//   uart_dataready RX holding register holds an unread byte
//   uart_tbre      TX holding register empty
//   uart_tsre      TX shift register empty (line idle)
//   overrun        sticky: a received byte overwrote an unread byte
//   txd            serial out, idle high
//   rxd            serial in, asynchronous
// -----------------------------------------------------------------------------
module cpld_uart_responder #(
    parameter int unsigned BAUD_DIV = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rdn,
    input  logic       uart_wrn,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       uart_dataready,
    output logic       uart_tbre,
    output logic       uart_tsre,
    output logic       overrun,
    output logic       txd,
    input  logic       rxd
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'((BAUD_DIV / 2) - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(7);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_e;

    // Bus strobe history
    logic       rdn_prev_q, wrn_prev_q;
    logic       rd_rel_c, wr_rel_c;
    logic [7:0] data_o_q;

    // Transmitter
    ser_state_e       tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
    logic [BIT_W-1:0] tx_bit_q,   tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       tx_hold_q,  tx_hold_d;
    logic             tbre_q,     tbre_d;
    logic             tsre_q,     tsre_d;
    logic             txd_q,      txd_d;

    // Receiver
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             rx_fall_c;
    ser_state_e       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [BIT_W-1:0] rx_bit_q,   rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_hold_q,  rx_hold_d;
    logic             dr_q,       dr_d;
    logic             ovr_q,      ovr_d;

    // A release is the first edge that sees the strobe high again
    assign rd_rel_c  = uart_rdn & ~rdn_prev_q;
    assign wr_rel_c  = uart_wrn & ~wrn_prev_q;
    assign rx_fall_c = rx_prev_q & ~rx_s2_q;

    assign data_oe        = ~uart_rdn;
    assign data_o         = data_o_q;
    assign uart_dataready = dr_q;
    assign uart_tbre      = tbre_q;
    assign uart_tsre      = tsre_q;
    assign overrun        = ovr_q;
    assign txd            = txd_q;

    // Write acceptance and transmit sequencing
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tbre_d     = tbre_q;
        tsre_d     = tsre_q;
        txd_d      = txd_q;

        // A write while the holding register is still full is dropped.
        // Loads below only fire with tbre_q=0, so the two never collide.
        if (wr_rel_c && tbre_q) begin
            tx_hold_d = data_i;
            tbre_d    = 1'b0;
        end

        unique case (tx_state_q)
            S_IDLE: begin
                if (!tbre_q) begin
                    tx_shift_d = tx_hold_q;
                    tbre_d     = 1'b1;
                    tsre_d     = 1'b0;
                    txd_d      = 1'b0;
                    tx_cnt_d   = BIT_RELOAD;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = '0;
                    tx_cnt_d   = BIT_RELOAD;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_RELOAD;
                    if (tx_bit_q == LAST_BIT) begin
                        txd_d      = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (!tbre_q) begin
                        // Pending byte: chain straight into its start bit
                        tx_shift_d = tx_hold_q;
                        tbre_d     = 1'b1;
                        txd_d      = 1'b0;
                        tx_cnt_d   = BIT_RELOAD;
                        tx_state_d = S_START;
                    end else begin
                        tsre_d     = 1'b1;
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // Receive sequencing and RX status flags
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_hold_d  = rx_hold_q;
        dr_d       = dr_q;
        ovr_d      = ovr_q;

        if (rd_rel_c) begin
            dr_d  = 1'b0;
            ovr_d = 1'b0;
        end

        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_fall_c) begin
                    rx_cnt_d   = HALF_RELOAD;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    // Still low at mid-bit: genuine start, otherwise a glitch
                    if (!rx_s2_q) begin
                        rx_cnt_d   = BIT_RELOAD;
                        rx_bit_d   = '0;
                        rx_state_d = S_DATA;
                    end else begin
                        rx_state_d = S_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_RELOAD;
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    // Framing error (stop=0) drops the byte silently
                    if (rx_s2_q) begin
                        rx_hold_d = rx_shift_q;
                        dr_d      = 1'b1;
                        // A read releasing on this edge consumed the old byte
                        if (dr_q && !rd_rel_c) begin
                            ovr_d = 1'b1;
                        end
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_prev_q <= 1'b1;
            wrn_prev_q <= 1'b1;
            data_o_q   <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_hold_q  <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_hold_q  <= '0;
            dr_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rdn_prev_q <= uart_rdn;
            wrn_prev_q <= uart_wrn;
            data_o_q   <= rx_hold_q;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tbre_q     <= tbre_d;
            tsre_q     <= tsre_d;
            txd_q      <= txd_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_hold_q  <= rx_hold_d;
            dr_q       <= dr_d;
            ovr_q      <= ovr_d;
        end
    end

endmodule

// File: tb/tb_cpld_uart_responder.sv
// -----------------------------------------------------------------------------
// tb_cpld_uart_responder
// Self-checking bench for cpld_uart_responder at BAUD_DIV=16. TX bytes are
// queued on write and popped by a serial line monitor; RX bytes are queued
// when a frame is driven and popped by bus reads.
// -----------------------------------------------------------------------------
module tb_cpld_uart_responder;

    localparam int unsigned BD = 16;

    logic       clk;
    logic       rst;
    logic       rdn;
    logic       wrn;
    logic [7:0] din;
    logic [7:0] dout;
    logic       doe;
    logic       dr;
    logic       tbre;
    logic       tsre;
    logic       ovr;
    logic       txd;
    logic       rxd;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    bit          mon_en;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    int unsigned tx_starts[$];
    logic        exp_ovr;
    logic [7:0]  last_hold;
    int          rx_lat;

    cpld_uart_responder #(.BAUD_DIV(BD)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .uart_rdn       (rdn),
        .uart_wrn       (wrn),
        .data_i         (din),
        .data_o         (dout),
        .data_oe        (doe),
        .uart_dataready (dr),
        .uart_tbre      (tbre),
        .uart_tsre      (tsre),
        .overrun        (ovr),
        .txd            (txd),
        .rxd            (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus write: wrn low for two edges, released on the following edge
    task automatic do_write(input logic [7:0] b, input bit accepted);
        @(negedge clk);
        wrn = 1'b0;
        din = b;
        @(negedge clk);
        @(negedge clk);
        wrn = 1'b1;
        if (accepted) tx_q.push_back(b);
    endtask

    // Bus read: compare the lane against the oldest unread expected byte
    task automatic do_read();
        logic [7:0] exp_b;
        check("rd_dataready", 32'(dr), 32'd1);
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        check("rd_oe_on", 32'(doe), 32'd1);
        check("rd_queue_has_byte", 32'(rx_q.size() != 0), 32'd1);
        exp_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        check("rd_data", 32'(dout), 32'(exp_b));
        check("rd_overrun", 32'(ovr), 32'(exp_ovr));
        rdn = 1'b1;
        @(negedge clk);
        check("rd_oe_off", 32'(doe), 32'd0);
        check("rd_dr_clear", 32'(dr), 32'd0);
        check("rd_ovr_clear", 32'(ovr), 32'd0);
        exp_ovr   = 1'b0;
        last_hold = exp_b;
    endtask

    // Drive one 8N1 frame on rxd and record when dataready first appears
    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        int         n;
        bit         seen;
        fr   = {stop_ok, b, 1'b0};
        n    = 0;
        seen = 1'b0;
        rx_lat = -1;
        for (int k = 0; k < 10; k++) begin
            rxd = fr[k];
            repeat (BD) begin
                @(negedge clk);
                n++;
                if (dr && !seen) begin
                    seen   = 1'b1;
                    rx_lat = n;
                end
            end
        end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (stop_ok) begin
            if (rx_q.size() != 0) begin
                exp_ovr = 1'b1;
                rx_q.delete();
            end
            rx_q.push_back(b);
        end
    endtask

    // TX line monitor: decode each frame at mid-bit and pop the scoreboard
    initial begin
        logic [7:0] b;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (mon_en && rst && txd == 1'b0) begin
                tx_starts.push_back(cyc);
                repeat (BD / 2) @(negedge clk);
                check("tx_start_bit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BD) @(negedge clk);
                check("tx_stop_bit", 32'(txd), 32'd1);
                check("tx_frame_expected", 32'(tx_q.size() != 0), 32'd1);
                exp_b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
                check("tx_byte", 32'(b), 32'(exp_b));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        mon_en    = 1'b0;
        exp_ovr   = 1'b0;
        last_hold = 8'h00;
        rx_lat    = -1;
        rst = 1'b0;
        rdn = 1'b1;
        wrn = 1'b1;
        din = 8'h00;
        rxd = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tbre", 32'(tbre), 32'd1);
        check("rst_tsre", 32'(tsre), 32'd1);
        check("rst_dr", 32'(dr), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_oe", 32'(doe), 32'd0);
        rst = 1'b1;

        // Reset asserted mid-frame on both TX and RX
        do_write(8'h00, 1'b0);
        rxd = 1'b0;
        repeat (60) @(negedge clk);
        check("midframe_tx_busy", 32'(tsre), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_tbre", 32'(tbre), 32'd1);
        check("midrst_tsre", 32'(tsre), 32'd1);
        check("midrst_dr", 32'(dr), 32'd0);
        check("midrst_oe", 32'(doe), 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("post_rst_dr", 32'(dr), 32'd0);
        check("post_rst_txd", 32'(txd), 32'd1);
        check("post_rst_tsre", 32'(tsre), 32'd1);
        mon_en = 1'b1;

        // Single write 0xA5 with exact status timing
        do_write(8'hA5, 1'b1);
        @(negedge clk);
        check("wr_tbre_after_E", 32'(tbre), 32'd0);
        check("wr_tsre_after_E", 32'(tsre), 32'd1);
        check("wr_txd_after_E", 32'(txd), 32'd1);
        @(negedge clk);
        check("wr_tbre_after_E1", 32'(tbre), 32'd1);
        check("wr_tsre_after_E1", 32'(tsre), 32'd0);
        check("wr_txd_start", 32'(txd), 32'd0);
        repeat (159) @(negedge clk);
        check("wr_tsre_in_stop", 32'(tsre), 32'd0);
        check("wr_txd_in_stop", 32'(txd), 32'd1);
        @(negedge clk);
        check("wr_tsre_done", 32'(tsre), 32'd1);
        repeat (20) @(negedge clk);

        // Back-to-back frames; a third write while full is dropped
        tx_starts.delete();
        do_write(8'h55, 1'b1);
        for (int i = 0; i < 20 && !tbre; i++) @(negedge clk);
        check("b2b_tbre_reloaded", 32'(tbre), 32'd1);
        do_write(8'h0F, 1'b1);
        @(negedge clk);
        check("b2b_tbre_full", 32'(tbre), 32'd0);
        do_write(8'h77, 1'b0);
        @(negedge clk);
        check("b2b_ignored_tbre", 32'(tbre), 32'd0);
        for (int i = 0; i < 600 && !tsre; i++) @(negedge clk);
        check("b2b_tsre_idle", 32'(tsre), 32'd1);
        repeat (BD) @(negedge clk);
        check("b2b_frame_count", tx_starts.size(), 32'd2);
        if (tx_starts.size() >= 2)
            check("b2b_no_gap", tx_starts[1] - tx_starts[0], 32'(10 * BD));
        check("b2b_tx_queue_empty", tx_q.size(), 32'd0);

        // RX 0x3C with latency check, then read
        send_rx(8'h3C, 1'b1);
        check("rx_latency_window", 32'(rx_lat >= 150 && rx_lat <= 158), 32'd1);
        do_read();

        // Overrun: two bytes without a read
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check("ovr_set", 32'(ovr), 32'd1);
        do_read();

        // Framing error leaves flags and holding register unchanged
        send_rx(8'h99, 1'b0);
        repeat (40) @(negedge clk);
        check("frame_err_dr", 32'(dr), 32'd0);
        check("frame_err_ovr", 32'(ovr), 32'd0);
        check("frame_err_hold", 32'(dout), 32'(last_hold));

        // Short start glitch is rejected
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_dr", 32'(dr), 32'd0);
        check("glitch_hold", 32'(dout), 32'(last_hold));

        // A valid byte after the error cases is still received
        send_rx(8'hC3, 1'b1);
        check("rx_after_err_dr", 32'(dr), 32'd1);
        do_read();

        check("final_rx_queue_empty", rx_q.size(), 32'd0);
        check("final_tx_queue_empty", tx_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
